// File: rtl/hydra_uart_pkg.sv
// Shared definitions for the UART transmit FIFO: drain FSM encoding and status word layout.
package hydra_uart_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned STAT_W = 32;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_LAUNCH = 2'd1;
  localparam logic [1:0] ST_BUSY   = 2'd2;

  localparam int unsigned STAT_EMPTY_BIT = 0;
  localparam int unsigned STAT_FULL_BIT  = 1;
  localparam int unsigned STAT_OVF_BIT   = 2;
  localparam int unsigned STAT_BUSY_BIT  = 3;
  localparam int unsigned STAT_COUNT_LSB = 8;
  localparam int unsigned STAT_COUNT_W   = 9;

  typedef struct packed {
    logic [14:0] rsvd_hi;
    logic [8:0]  count;
    logic [3:0]  rsvd_lo;
    logic        busy;
    logic        overflow;
    logic        full;
    logic        empty;
  } status_t;

  // Assemble the status word; unlisted bits stay zero.
  function automatic status_t pack_status(input logic empty, input logic full,
                                          input logic overflow, input logic busy,
                                          input logic [STAT_COUNT_W-1:0] count);
    logic [STAT_W-1:0] w;
    w = '0;
    w[STAT_EMPTY_BIT] = empty;
    w[STAT_FULL_BIT]  = full;
    w[STAT_OVF_BIT]   = overflow;
    w[STAT_BUSY_BIT]  = busy;
    w[STAT_COUNT_LSB +: STAT_COUNT_W] = count;
    return status_t'(w);
  endfunction

endpackage

// File: rtl/uart_tx_fifo_if.sv
// Bus and UART-side signal bundle for uart_tx_fifo; master drives requests and tx_ready, slave is the FIFO.
interface uart_tx_fifo_if;
  import hydra_uart_pkg::*;

  logic              wr_valid;
  logic [BYTE_W-1:0] wr_data;
  logic              wr_ack;
  logic              rd_valid;
  logic [STAT_W-1:0] rd_data;
  logic              rd_ack;
  logic [BYTE_W-1:0] tx_data;
  logic              tx_send;
  logic              tx_ready;

  modport master (
    output wr_valid, wr_data, rd_valid, tx_ready,
    input  wr_ack, rd_data, rd_ack, tx_data, tx_send
  );

  modport slave (
    input  wr_valid, wr_data, rd_valid, tx_ready,
    output wr_ack, rd_data, rd_ack, tx_data, tx_send
  );

endinterface

// File: rtl/sync_fifo_ram.sv
// FIFO storage: one write port and one registered read port with read-before-write behaviour.
module sync_fifo_ram #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_wr_en,
  input  logic [$clog2(DEPTH)-1:0] i_wr_addr,
  input  logic [WIDTH-1:0]         i_wr_data,
  input  logic                     i_rd_en,
  input  logic [$clog2(DEPTH)-1:0] i_rd_addr,
  output logic [WIDTH-1:0]         o_rd_data
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rd_data;

  always_ff @(posedge clk) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
  end

  // Read register holds its value between reads so the consumer sees a stable byte.
  always_ff @(posedge clk) begin
    if (reset) r_rd_data <= '0;
    else if (i_rd_en) r_rd_data <= r_mem[i_rd_addr];
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/uart_tx_fifo.sv
// Bus-writable transmit FIFO draining bytes into a UART via a send/ready handshake.
// Define UART_TX_FIFO_NONBLOCK_EN to drop writes to a full FIFO (sticky overflow) instead of stalling.
module uart_tx_fifo
  import hydra_uart_pkg::*;
#(
  parameter int unsigned DEPTH = 16
) (
  input logic           clk,
  input logic           reset,
  uart_tx_fifo_if.slave bus
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [CW-1:0]     r_count;
  logic [1:0]        r_state;
  logic [1:0]        w_state_next;
  logic              r_overflow;
  logic              r_wr_ack;
  logic              r_rd_ack;
  logic              r_tx_send;
  logic [STAT_W-1:0] r_rd_data;
  logic [BYTE_W-1:0] w_ram_q;
  logic              w_full;
  logic              w_empty;
  logic              w_busy;
  logic              w_pop;
  logic              w_wr_req;
  logic              w_rd_req;
  logic              w_push;
  logic              w_wr_ack_set;
  logic              w_ovf_set;

  assign w_full   = (r_count == CW'(DEPTH));
  assign w_empty  = (r_count == '0);
  assign w_busy   = (r_state != ST_IDLE) || !w_empty;
  assign w_wr_req = bus.wr_valid && !r_wr_ack;
  assign w_rd_req = bus.rd_valid && !r_rd_ack;

  // A pop on the same edge frees a slot, so a full FIFO may still take the push.
`ifdef UART_TX_FIFO_NONBLOCK_EN
  assign w_wr_ack_set = w_wr_req;
  assign w_push       = w_wr_req && (!w_full || w_pop);
  assign w_ovf_set    = w_wr_req && w_full && !w_pop;
`else
  assign w_wr_ack_set = w_wr_req && (!w_full || w_pop);
  assign w_push       = w_wr_ack_set;
  assign w_ovf_set    = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else r_state <= w_state_next;
  end

  // Drain FSM: launch one byte, wait for the UART to go busy, then wait for it to finish.
  always_comb begin
    w_state_next = r_state;
    w_pop        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_empty && bus.tx_ready) begin
          w_pop        = 1'b1;
          w_state_next = ST_LAUNCH;
        end
      end
      ST_LAUNCH: if (!bus.tx_ready) w_state_next = ST_BUSY;
      ST_BUSY:   if (bus.tx_ready) w_state_next = ST_IDLE;
      default:   w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Overflow set takes priority so a drop coinciding with a read is not lost.
  always_ff @(posedge clk) begin
    if (reset) r_overflow <= 1'b0;
    else if (w_ovf_set) r_overflow <= 1'b1;
    else if (w_rd_req) r_overflow <= 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ack  <= 1'b0;
      r_rd_ack  <= 1'b0;
      r_tx_send <= 1'b0;
      r_rd_data <= '0;
    end else begin
      r_wr_ack  <= w_wr_ack_set;
      r_rd_ack  <= w_rd_req;
      r_tx_send <= w_pop;
      if (w_rd_req) begin
        r_rd_data <= pack_status(w_empty, w_full, r_overflow, w_busy, STAT_COUNT_W'(r_count));
      end
    end
  end

  sync_fifo_ram #(
    .DEPTH (DEPTH),
    .WIDTH (BYTE_W)
  ) u_ram (
    .clk       (clk),
    .reset     (reset),
    .i_wr_en   (w_push),
    .i_wr_addr (r_wr_ptr),
    .i_wr_data (bus.wr_data),
    .i_rd_en   (w_pop),
    .i_rd_addr (r_rd_ptr),
    .o_rd_data (w_ram_q)
  );

  assign bus.wr_ack  = r_wr_ack;
  assign bus.rd_ack  = r_rd_ack;
  assign bus.rd_data = r_rd_data;
  assign bus.tx_send = r_tx_send;
  assign bus.tx_data = w_ram_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: queue-based reference model, UART stub, directed and random traffic.
module tb_uart_tx_fifo;

  localparam int unsigned DEPTH = 16;

  logic clk;
  logic reset;

  uart_tx_fifo_if bus ();

  uart_tx_fifo #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model state: FIFO contents as a queue, drain phase 0=idle 1=launched 2=uart busy.
  byte unsigned m_q[$];
  int           m_phase;
  bit           m_wr_ack;
  bit           m_rd_ack;
  bit           m_tx_send;
  bit           m_ovf;
  logic [7:0]   m_tx_data;
  logic [31:0]  m_rd_data;

  byte unsigned tx_log[$];
  bit           uart_hold;
  int           uart_cnt;
  int           n_checks;
  int           n_fail;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance the model across the coming rising edge using the inputs currently applied.
  task automatic model_step();
    int  cnt;
    bit  full;
    bit  pop;
    bit  wr_try;
    bit  rd_try;
    bit  accept;
    bit  store;
    bit  busy;
    if (reset) begin
      m_q.delete();
      m_phase   = 0;
      m_wr_ack  = 0;
      m_rd_ack  = 0;
      m_tx_send = 0;
      m_ovf     = 0;
      m_tx_data = 8'h00;
      m_rd_data = 32'h0;
      return;
    end
    cnt    = m_q.size();
    full   = (cnt == int'(DEPTH));
    pop    = (m_phase == 0) && (cnt > 0) && (bus.tx_ready == 1'b1);
    wr_try = (bus.wr_valid == 1'b1) && !m_wr_ack;
    rd_try = (bus.rd_valid == 1'b1) && !m_rd_ack;
    busy   = (m_phase != 0) || (cnt > 0);
    if (rd_try) begin
      m_rd_data = (32'(cnt) << 8) | (32'(busy) << 3) | (32'(m_ovf) << 2)
                | (32'(full) << 1) | 32'(cnt == 0);
    end
`ifdef UART_TX_FIFO_NONBLOCK_EN
    accept = wr_try;
    store  = wr_try && (!full || pop);
    if (wr_try && full && !pop) m_ovf = 1;
    else if (rd_try) m_ovf = 0;
`else
    accept = wr_try && (!full || pop);
    store  = accept;
`endif
    m_rd_ack  = rd_try;
    m_wr_ack  = accept;
    m_tx_send = pop;
    if (pop) m_tx_data = m_q.pop_front();
    if (store) m_q.push_back(bus.wr_data);
    case (m_phase)
      0: if (pop) m_phase = 1;
      1: if (bus.tx_ready == 1'b0) m_phase = 2;
      default: if (bus.tx_ready == 1'b1) m_phase = 0;
    endcase
  endtask

  // One clock: model update, compare on the falling edge, then the UART stub reacts.
  task automatic tick();
    model_step();
    @(negedge clk);
    check("wr_ack", 32'(bus.wr_ack), 32'(m_wr_ack));
    check("rd_ack", 32'(bus.rd_ack), 32'(m_rd_ack));
    check("rd_data", bus.rd_data, m_rd_data);
    check("tx_send", 32'(bus.tx_send), 32'(m_tx_send));
    check("tx_data", 32'(bus.tx_data), 32'(m_tx_data));
    if (bus.tx_send === 1'b1) begin
      tx_log.push_back(bus.tx_data);
      uart_cnt = 1 + int'($urandom_range(0, 3));
    end else if (uart_cnt > 0) begin
      uart_cnt--;
    end
    bus.tx_ready = !uart_hold && (uart_cnt == 0);
  endtask

  task automatic write_byte(input logic [7:0] b, input int budget);
    bus.wr_valid = 1'b1;
    bus.wr_data  = b;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (bus.wr_ack === 1'b1) begin
        bus.wr_valid = 1'b0;
        return;
      end
    end
    n_checks++;
    n_fail++;
    $display("FAIL write_timeout: byte 0x%02h not acknowledged within %0d cycles", b, budget);
    bus.wr_valid = 1'b0;
  endtask

  task automatic read_status(output logic [31:0] s);
    bus.rd_valid = 1'b1;
    s = 32'hxxxx_xxxx;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (bus.rd_ack === 1'b1) begin
        s = bus.rd_data;
        bus.rd_valid = 1'b0;
        return;
      end
    end
    n_checks++;
    n_fail++;
    $display("FAIL read_timeout: status read not acknowledged");
    bus.rd_valid = 1'b0;
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (m_q.size() == 0 && m_phase == 0) return;
      tick();
    end
    n_checks++;
    n_fail++;
    $display("FAIL drain_timeout: %0d bytes still queued", m_q.size());
  endtask

  task automatic hold_uart(input bit h);
    uart_hold    = h;
    bus.tx_ready = !h && (uart_cnt == 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] st;
    int          n_before;
    n_checks     = 0;
    n_fail       = 0;
    uart_hold    = 0;
    uart_cnt     = 0;
    reset        = 1'b1;
    bus.wr_valid = 1'b0;
    bus.wr_data  = 8'h00;
    bus.rd_valid = 1'b0;
    bus.tx_ready = 1'b1;

    // Reset state
    repeat (3) tick();
    check("rst_wr_ack", 32'(bus.wr_ack), 32'h0);
    check("rst_tx_send", 32'(bus.tx_send), 32'h0);
    check("rst_tx_data", 32'(bus.tx_data), 32'h0);
    check("rst_rd_data", bus.rd_data, 32'h0);
    reset = 1'b0;
    read_status(st);
    check("rst_status", st, 32'h0000_0001);

    // Single byte
    tx_log.delete();
    write_byte(8'h41, 4);
    drain(40);
    check("single_count", 32'(tx_log.size()), 32'd1);
    if (tx_log.size() > 0) check("single_byte", 32'(tx_log[0]), 32'h41);
    read_status(st);
    check("single_status", st, 32'h0000_0001);

    // Burst into a held UART, then full-FIFO behaviour
    tx_log.delete();
    hold_uart(1);
    for (int i = 0; i < 16; i++) write_byte(8'(i), 4);
    read_status(st);
    check("burst_full_status", st, 32'h0000_100A);
`ifdef UART_TX_FIFO_NONBLOCK_EN
    write_byte(8'hAA, 1);
    read_status(st);
    check("ovf_first_read", st, 32'h0000_100E);
    read_status(st);
    check("ovf_second_read", st, 32'h0000_100A);
    hold_uart(0);
    drain(200);
    check("ovf_sent_count", 32'(tx_log.size()), 32'd16);
`else
    bus.wr_valid = 1'b1;
    bus.wr_data  = 8'h55;
    repeat (4) begin
      tick();
      check("stall_ack_low", 32'(bus.wr_ack), 32'h0);
    end
    hold_uart(0);
    write_byte(8'h55, 4);
    read_status(st);
    check("simul_count16", st, 32'h0000_100A);
    drain(200);
    check("stall_sent_count", 32'(tx_log.size()), 32'd17);
    if (tx_log.size() == 17) check("stall_last_byte", 32'(tx_log[16]), 32'h55);
`endif
    for (int i = 0; i < 16; i++) begin
      if (i < tx_log.size()) check("burst_order", 32'(tx_log[i]), 32'(i));
    end
    read_status(st);
    check("burst_empty", st, 32'h0000_0001);

    // Randomized traffic with a UART that stalls for long stretches
    for (int c = 0; c < 4000; c++) begin
      if (bus.wr_valid === 1'b1 && bus.wr_ack === 1'b1) bus.wr_valid = 1'b0;
      else if (bus.wr_valid === 1'b0 && $urandom_range(0, 2) == 0) begin
        bus.wr_valid = 1'b1;
        bus.wr_data  = 8'($urandom);
      end
      if (bus.rd_valid === 1'b1 && bus.rd_ack === 1'b1) bus.rd_valid = 1'b0;
      else if (bus.rd_valid === 1'b0 && $urandom_range(0, 7) == 0) bus.rd_valid = 1'b1;
      if ($urandom_range(0, 99) == 0) uart_hold = !uart_hold;
      tick();
    end
    bus.wr_valid = 1'b0;
    bus.rd_valid = 1'b0;
    tick();
    hold_uart(0);
    drain(400);

    // Reset while the UART is busy with a byte and five remain queued
    tx_log.delete();
    hold_uart(1);
    for (int i = 0; i < 6; i++) write_byte(8'(8'h60 + i), 4);
    hold_uart(0);
    for (int i = 0; i < 20 && tx_log.size() == 0; i++) tick();
    hold_uart(1);
    read_status(st);
    check("busy_status", st, 32'h0000_0508);
    n_before = tx_log.size();
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    hold_uart(0);
    repeat (20) tick();
    check("no_send_after_reset", 32'(tx_log.size()), 32'(n_before));
    read_status(st);
    check("post_reset_status", st, 32'h0000_0001);

    // Write request held across reset release
    reset        = 1'b1;
    bus.wr_valid = 1'b1;
    bus.wr_data  = 8'h77;
    repeat (2) tick();
    reset = 1'b0;
    write_byte(8'h77, 4);
    drain(40);
    check("held_req_sent", 32'(tx_log.size()), 32'(n_before + 1));
    if (tx_log.size() > 0) check("held_req_byte", 32'(tx_log[tx_log.size() - 1]), 32'h77);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
